// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
`timescale 1ns/1ps
package pll_seq_pkg;

  typedef enum logic [1:0] {
    RESET_PLL   = 2'd0,
    WAIT_LOCK   = 2'd1,
    STABLE_WAIT = 2'd2,
    RUN         = 2'd3
  } pll_state_e;

  localparam int unsigned RELOCK_CNT_W       = 8;
  localparam int unsigned LOSS_FILTER_CYCLES = 4;
  localparam int unsigned LOSS_FILT_W        = $clog2(LOSS_FILTER_CYCLES);

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up sequencer and lock supervisor on the free-running reference clock.
// Optional RUN-state lock-loss glitch filter: define PLL_SEQ_LOSS_FILTER_EN.
`timescale 1ns/1ps
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES          = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pll_locked,
  input  logic                    restart_req,
  output logic                    pll_rst,
  output logic                    core_reset,
  output logic                    core_ready,
  output logic                    timeout_err,
  output logic [RELOCK_CNT_W-1:0] relock_count,
  output logic [1:0]              state
);

  localparam int unsigned CNT_W = $clog2(max3(RST_CYCLES, LOCK_STABLE_CYCLES,
                                              LOCK_TIMEOUT_CYCLES)) + 1;

  logic                    lock_s;
  pll_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pll_rst_q, pll_rst_d;
  logic                    core_reset_q, core_reset_d;
  logic                    core_ready_q, core_ready_d;
  logic                    timeout_q, timeout_d;
  logic [RELOCK_CNT_W-1:0] relock_q, relock_d;
  logic                    loss;

  sync_2ff u_lock_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

`ifdef PLL_SEQ_LOSS_FILTER_EN
  logic [LOSS_FILT_W-1:0] filt_q, filt_d;

  // Loss is declared on the 4th consecutive low cycle; the counter never wraps.
  always_comb begin
    loss   = (state_q == RUN) && !lock_s &&
             (filt_q == LOSS_FILT_W'(LOSS_FILTER_CYCLES - 1));
    filt_d = '0;
    if ((state_q == RUN) && !lock_s && !restart_req && !loss)
      filt_d = filt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) filt_q <= '0;
    else          filt_q <= filt_d;
  end
`else
  always_comb loss = (state_q == RUN) && !lock_s;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    timeout_d = timeout_q;
    relock_d  = relock_q;
    if (restart_req) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            state_d   = RESET_PLL;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end
        end
        STABLE_WAIT: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          cnt_d = '0;
          if (loss) begin
            state_d = RESET_PLL;
            if (relock_q != '1) relock_d = relock_q + 1'b1;
          end
        end
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
    // Outputs are decoded from the next state so they flip on the entering edge.
    pll_rst_d    = (state_d == RESET_PLL);
    core_ready_d = (state_d == RUN);
    core_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RESET_PLL;
      cnt_q        <= '0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      core_ready_q <= 1'b0;
      timeout_q    <= 1'b0;
      relock_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_rst_q    <= pll_rst_d;
      core_reset_q <= core_reset_d;
      core_ready_q <= core_ready_d;
      timeout_q    <= timeout_d;
      relock_q     <= relock_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign core_reset   = core_reset_q;
  assign core_ready   = core_ready_q;
  assign timeout_err  = timeout_q;
  assign relock_count = relock_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer with RST=4, STABLE=8, TIMEOUT=32.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  typedef struct packed {
    logic [1:0] st;
    logic       prst;
    logic       crst;
    logic       rdy;
    logic       terr;
    logic [7:0] rc;
  } obs_t;

  typedef struct {
    int unsigned cyc;
    obs_t        v;
    string       tag;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       core_reset;
  logic       core_ready;
  logic       timeout_err;
  logic [7:0] relock_count;
  logic [1:0] state;
  obs_t       obs;

  exp_t        sb[$];
  exp_t        e;
  int unsigned vectors;
  int unsigned miscompares;

  pll_reset_sequencer #(
    .RST_CYCLES          (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .restart_req  (restart_req),
    .pll_rst      (pll_rst),
    .core_reset   (core_reset),
    .core_ready   (core_ready),
    .timeout_err  (timeout_err),
    .relock_count (relock_count),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb obs = {state, pll_rst, core_reset, core_ready, timeout_err, relock_count};

  // Expected outputs for a state: pll_rst only in RESET_PLL, ready only in RUN.
  function automatic obs_t mk(input pll_state_e s, input logic terr, input logic [7:0] rc);
    obs_t o;
    o.st   = s;
    o.prst = (s == RESET_PLL);
    o.rdy  = (s == RUN);
    o.crst = (s != RUN);
    o.terr = terr;
    o.rc   = rc;
    return o;
  endfunction

  task automatic push(input int unsigned c, input pll_state_e s, input logic terr,
                      input logic [7:0] rc, input string tag);
    exp_t x;
    x.cyc = c;
    x.v   = mk(s, terr, rc);
    x.tag = tag;
    sb.push_back(x);
  endtask

  // Release lands 1 ns after an edge; cycle k is the state after k edges.
  task automatic apply_reset();
    reset_n     = 1'b0;
    pll_locked  = 1'b0;
    restart_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    pll_locked  = 1'b1;
    restart_req = 1'b1;
    #3;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (obs !== mk(RESET_PLL, 1'b0, 8'd0)) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want %h", obs, mk(RESET_PLL, 1'b0, 8'd0));
    end
  endtask

  task automatic test_power_up();
    apply_reset();
    push(0,  RESET_PLL,   0, 0, "pu_rst0");
    push(3,  RESET_PLL,   0, 0, "pu_rst3");
    push(4,  WAIT_LOCK,   0, 0, "pu_wait");
    push(12, WAIT_LOCK,   0, 0, "pu_sync");
    push(13, STABLE_WAIT, 0, 0, "pu_stable");
    push(20, STABLE_WAIT, 0, 0, "pu_stable_end");
    push(21, RUN,         0, 0, "pu_run");
    push(30, RUN,         0, 0, "pu_run_hold");
    for (int unsigned c = 0; c <= 30; c++) begin
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      if (c == 10) pll_locked = 1'b1;
      if (c < 30) begin @(posedge clk); #1; end
    end
    if (sb.size() != 0) begin
      miscompares += sb.size();
      $display("FAIL pu_unconsumed: got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    push(4,  WAIT_LOCK, 0, 0, "to_wait");
    push(35, WAIT_LOCK, 0, 0, "to_last");
    push(36, RESET_PLL, 1, 0, "to_rerst");
    push(39, RESET_PLL, 1, 0, "to_rerst_end");
    push(40, WAIT_LOCK, 1, 0, "to_wait2");
    push(71, WAIT_LOCK, 1, 0, "to_last2");
    push(72, RESET_PLL, 1, 0, "to_rerst2");
    push(76, WAIT_LOCK, 1, 0, "to_sticky");
    for (int unsigned c = 0; c <= 76; c++) begin
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      if (c < 76) begin @(posedge clk); #1; end
    end
    if (sb.size() != 0) begin
      miscompares += sb.size();
      $display("FAIL to_unconsumed: got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout_lock_tie();
    apply_reset();
    push(35, WAIT_LOCK,   0, 0, "tie_last");
    push(36, STABLE_WAIT, 0, 0, "tie_stable");
    push(44, RUN,         0, 0, "tie_run");
    for (int unsigned c = 0; c <= 44; c++) begin
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      if (c == 33) pll_locked = 1'b1;
      if (c < 44) begin @(posedge clk); #1; end
    end
    if (sb.size() != 0) begin
      miscompares += sb.size();
      $display("FAIL tie_unconsumed: got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_stable_glitch();
    apply_reset();
    push(17, STABLE_WAIT, 0, 0, "gl_stable");
    push(18, WAIT_LOCK,   0, 0, "gl_back");
    push(19, STABLE_WAIT, 0, 0, "gl_restable");
    push(26, STABLE_WAIT, 0, 0, "gl_full8");
    push(27, RUN,         0, 0, "gl_run");
    for (int unsigned c = 0; c <= 28; c++) begin
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      if (c == 10) pll_locked = 1'b1;
      if (c == 15) pll_locked = 1'b0;
      if (c == 16) pll_locked = 1'b1;
      if (c < 28) begin @(posedge clk); #1; end
    end
    if (sb.size() != 0) begin
      miscompares += sb.size();
      $display("FAIL gl_unconsumed: got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_run_loss();
    apply_reset();
    push(27, RUN,         0, 0, "rl_pre");
`ifdef PLL_SEQ_LOSS_FILTER_EN
    push(28, RUN,         0, 0, "rl_filtered");
    push(35, RUN,         0, 0, "rl_filtered_hold");
    push(45, RUN,         0, 0, "rl_long_pre");
    push(46, RESET_PLL,   0, 1, "rl_long_loss");
`else
    push(28, RESET_PLL,   0, 1, "rl_loss");
    push(31, RESET_PLL,   0, 1, "rl_rst_end");
    push(32, WAIT_LOCK,   0, 1, "rl_wait");
    push(33, STABLE_WAIT, 0, 1, "rl_stable");
    push(41, RUN,         0, 1, "rl_rerun");
`endif
    for (int unsigned c = 0; c <= 46; c++) begin
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      if (c == 10) pll_locked = 1'b1;
      if (c == 25) pll_locked = 1'b0;
      if (c == 27) pll_locked = 1'b1;
`ifdef PLL_SEQ_LOSS_FILTER_EN
      if (c == 40) pll_locked = 1'b0;
      if (c == 46) pll_locked = 1'b1;
`endif
      if (c < 46) begin @(posedge clk); #1; end
    end
    if (sb.size() != 0) begin
      miscompares += sb.size();
      $display("FAIL rl_unconsumed: got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_restart();
    apply_reset();
    push(26, RUN,         0, 0, "rs_run");
    push(28, RESET_PLL,   0, 0, "rs_restart");
    push(31, RESET_PLL,   0, 0, "rs_extend0");
    push(34, RESET_PLL,   0, 0, "rs_extend3");
    push(35, WAIT_LOCK,   0, 0, "rs_wait");
    push(36, STABLE_WAIT, 0, 0, "rs_stable");
    for (int unsigned c = 0; c <= 36; c++) begin
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if (obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got %h want %h", e.tag, c, obs, e.v);
        end
      end
      if (c == 10) pll_locked = 1'b1;
      if (c == 25) pll_locked = 1'b0;
      if (c == 27) restart_req = 1'b1;
      if (c == 28) begin restart_req = 1'b0; pll_locked = 1'b1; end
      if (c == 30) restart_req = 1'b1;
      if (c == 31) restart_req = 1'b0;
      if (c < 36) begin @(posedge clk); #1; end
    end
    if (sb.size() != 0) begin
      miscompares += sb.size();
      $display("FAIL rs_unconsumed: got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_saturation();
    int unsigned n;
    apply_reset();
    pll_locked = 1'b1;
    for (int unsigned i = 1; i <= 300; i++) begin
      n = 0;
      while (state !== 2'(RUN) && n < 200) begin @(posedge clk); #1; n++; end
      if (n >= 200) begin
        miscompares++;
        $display("FAIL sat_run_wait iter %0d: got state %0d want %0d", i, state, RUN);
        break;
      end
      pll_locked = 1'b0;
      push(0, RESET_PLL, 0, (i > 255) ? 8'd255 : 8'(i), "sat_loss");
      n = 0;
      while (state !== 2'(RESET_PLL) && n < 50) begin @(posedge clk); #1; n++; end
      e = sb.pop_front();
      vectors++;
      if (n >= 50 || obs !== e.v) begin
        miscompares++;
        $display("FAIL %s iter %0d: got %h want %h", e.tag, i, obs, e.v);
      end
      pll_locked = 1'b1;
    end
    n = 0;
    while (state !== 2'(STABLE_WAIT) && n < 100) begin @(posedge clk); #1; n++; end
    vectors++;
    if (obs !== mk(STABLE_WAIT, 1'b0, 8'd255)) begin
      miscompares++;
      $display("FAIL sat_final: got %h want %h", obs, mk(STABLE_WAIT, 1'b0, 8'd255));
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (obs !== mk(RESET_PLL, 1'b0, 8'd0)) begin
      miscompares++;
      $display("FAIL async_reset_mid: got %h want %h", obs, mk(RESET_PLL, 1'b0, 8'd0));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_power_up();
    test_timeout();
    test_timeout_lock_tie();
    test_stable_glitch();
    test_run_loss();
    test_restart();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
